// File: rtl/fir_filter.sv
// Streaming TAPS-tap FIR filter, signed Q8.8 samples and Q4.16 coefficients.
// Three-stage multiply / partial-sum / final-sum pipeline that never stalls.
module fir_filter #(
  parameter int TAPS = 32,
  parameter int DW   = 16,
  parameter int CW   = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_valid,
  input  logic [DW-1:0]            data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_din,
  output logic [DW-1:0]            fir_d,
  output logic                     fir_valid
);

  localparam int FW  = $clog2(TAPS) + 1;
  localparam int NG  = TAPS / 4;
  localparam int PW  = DW + CW;
  localparam int S2W = PW + 2;
  localparam int S3W = S2W + $clog2(NG);
  localparam int SHW = S3W - 16;
  localparam logic [FW-1:0]          FILL_FULL = FW'(TAPS);
  localparam logic [FW-1:0]          FILL_LAST = FW'(TAPS - 1);
  localparam logic signed [S3W-1:0]  RND_HALF  = {{(S3W-16){1'b0}}, 1'b1, 15'b0};

  logic signed [DW-1:0]  x_q    [TAPS];
  logic signed [CW-1:0]  c_q    [TAPS];
  logic signed [PW-1:0]  prod_q [TAPS];
  logic signed [S2W-1:0] psum_q [NG];
  logic [FW-1:0]         fill_q, fill_d;
  logic                  v0_q, v1_q, v2_q, fir_valid_q;
  logic [DW-1:0]         fir_d_q, sat_d;
  logic signed [S3W-1:0] acc_d, rnd_d;
  logic signed [SHW-1:0] shr_d;

  always_comb begin
    fill_d = fill_q;
    if (data_valid && fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
  end

  // S3: final sum, round half up, then clamp to the 16-bit signed range.
  always_comb begin
    acc_d = '0;
    for (int g = 0; g < NG; g++) acc_d = acc_d + S3W'(psum_q[g]);
    rnd_d = acc_d + RND_HALF;
    shr_d = rnd_d[S3W-1:16];
    sat_d = shr_d[DW-1:0];
    if (!(&shr_d[SHW-1:DW-1]) && (|shr_d[SHW-1:DW-1])) begin
      sat_d = shr_d[SHW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        c_q[k]    <= '0;
        prod_q[k] <= '0;
      end
      for (int g = 0; g < NG; g++) psum_q[g] <= '0;
      fill_q      <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      fir_valid_q <= 1'b0;
      fir_d_q     <= '0;
    end else begin
      if (data_valid) begin
        x_q[0] <= data;
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
      if (coef_we) c_q[coef_addr] <= coef_din;
      fill_q <= fill_d;
      // Tag marks samples that complete a full delay line (32nd or later).
      v0_q   <= data_valid && (fill_q >= FILL_LAST);
      for (int k = 0; k < TAPS; k++) prod_q[k] <= PW'(x_q[k]) * PW'(c_q[k]);
      for (int g = 0; g < NG; g++) begin
        psum_q[g] <= S2W'(prod_q[4*g])   + S2W'(prod_q[4*g+1]) +
                     S2W'(prod_q[4*g+2]) + S2W'(prod_q[4*g+3]);
      end
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      fir_valid_q <= v2_q;
      if (v2_q) fir_d_q <= sat_d;
    end
  end

  assign fir_d     = fir_d_q;
  assign fir_valid = fir_valid_q;

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboarded bench for fir_filter: a behavioural FIR model feeds an expected
// queue at drive time; a forked monitor checks every fir_valid pulse and its timing.
module tb_fir_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [15:0] data;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [19:0] coef_din;
  logic [15:0] fir_d;
  logic        fir_valid;

  fir_filter dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_din   (coef_din),
    .fir_d      (fir_d),
    .fir_valid  (fir_valid)
  );

  always #5 clk = ~clk;

  int          edge_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          due_q[$];
  int          hist[$];
  int          m_coef[32];

  function automatic logic [15:0] model_y();
    longint sum = 0;
    longint r;
    logic [15:0] y;
    for (int k = 0; k < 32; k++) sum += longint'(hist[k]) * longint'(m_coef[k]);
    r = (sum + 64'sd32768) >>> 16;
    if (r > 32767)       y = 16'h7FFF;
    else if (r < -32768) y = 16'h8000;
    else                 y = r[15:0];
    return y;
  endfunction

  task automatic do_reset();
    rst = 1'b1; data_valid = 1'b0; coef_we = 1'b0;
    exp_q.delete(); due_q.delete(); hist.delete();
    foreach (m_coef[k]) m_coef[k] = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit dv, input logic [15:0] d,
                      input bit we, input logic [4:0] a, input logic [19:0] cd);
    data_valid = dv; data = d; coef_we = we; coef_addr = a; coef_din = cd;
    if (we) m_coef[a] = int'($signed(cd));
    if (dv) begin
      hist.push_front(int'($signed(d)));
      if (hist.size() > 32) void'(hist.pop_back());
      if (hist.size() == 32) begin
        exp_q.push_back(model_y());
        due_q.push_back(edge_cnt + 4);
      end
    end
    @(negedge clk);
    data_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic load_coef(input int mode);
    for (int k = 0; k < 32; k++) begin
      case (mode)
        0:       step(0, 16'h0, 1, 5'(k), 20'((k + 1) * 256));
        1:       step(0, 16'h0, 1, 5'(k), 20'h7FFFF);
        default: step(0, 16'h0, 1, 5'(k), 20'($urandom_range(0, 20'hFFFFF)));
      endcase
    end
  endtask

  task automatic impulse(input int gap);
    for (int i = 0; i < 63; i++) begin
      step(1, (i == 31) ? 16'h0100 : 16'h0000, 0, 5'd0, 20'd0);
      repeat (gap) step(0, 16'h0, 0, 5'd0, 20'd0);
    end
  endtask

  task automatic monitor();
    logic [15:0] e;
    int          due;
    bit          r;
    forever begin
      @(posedge clk);
      edge_cnt++;
      r = rst;
      #1;
      if (r) begin
        n_vec++;
        if (fir_valid !== 1'b0 || fir_d !== 16'h0) begin
          n_err++;
          $display("FAIL reset_state edge=%0d fir_valid=%b fir_d=%h required 0/0000",
                   edge_cnt, fir_valid, fir_d);
        end
      end else if (fir_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_pulse edge=%0d fir_d=%h required no pulse", edge_cnt, fir_d);
        end else begin
          e = exp_q.pop_front();
          due = due_q.pop_front();
          if (fir_d !== e || due != edge_cnt) begin
            n_err++;
            $display("FAIL output edge=%0d fir_d=%h required fir_d=%h at edge %0d",
                     edge_cnt, fir_d, e, due);
          end
        end
      end else if (due_q.size() > 0 && due_q[0] <= edge_cnt) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_pulse edge=%0d required fir_d=%h", edge_cnt, exp_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    data = '0; coef_addr = '0; coef_din = '0;
    do_reset();

    // Impulse response, continuous then every other cycle.
    load_coef(0);
    impulse(0);
    do_reset();
    load_coef(0);
    impulse(1);

    // Saturation at both rails.
    do_reset();
    load_coef(1);
    repeat (40) step(1, 16'h7FFF, 0, 5'd0, 20'd0);
    repeat (40) step(1, 16'h8000, 0, 5'd0, 20'd0);

    // Round half up on a single half-weight tap.
    do_reset();
    step(0, 16'h0, 1, 5'd0, 20'h08000);
    repeat (34) step(1, 16'h0001, 0, 5'd0, 20'd0);
    repeat (34) step(1, 16'hFFFF, 0, 5'd0, 20'd0);

    // Random data, random gaps, coefficient writes landing alongside samples.
    do_reset();
    load_coef(2);
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) < 7, 16'($urandom_range(0, 16'hFFFF)),
           $urandom_range(0, 9) == 0, 5'($urandom_range(0, 31)),
           20'($urandom_range(0, 20'hFFFFF)));
    end

    // Reset with outputs in flight, then refill.
    repeat (40) step(1, 16'($urandom_range(0, 16'hFFFF)), 0, 5'd0, 20'd0);
    do_reset();
    load_coef(2);
    repeat (40) step(1, 16'($urandom_range(0, 16'hFFFF)), 0, 5'd0, 20'd0);

    repeat (8) step(0, 16'h0, 0, 5'd0, 20'd0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
